slot_dispatch_seq: RTL
======================

Name: slot_dispatch_seq

Overview:
- Read/consume side of the slot table: walks slots 0..(2^INDEX_WIDTH)-1 after a start pulse.
- For every slot with status READY, issues one MM2S (source) and one S2MM (destination) DMA command, and waits for both completions.
- Writes back final status and a cycle-count profile into the same slot through the table's index/set-strobe write port.
- Sits between the slot table and the DMA command/status interfaces of the DFX sequencer datapath.

Parameters:
INDEX_WIDTH, 2, slot index width (2^INDEX_WIDTH slots)
SRC_ADDR_WIDTH, 32, source address width
SRC_SIZE_WIDTH, 26, source byte-count width
DST_ADDR_WIDTH, 32, destination address width
DST_SIZE_WIDTH, 26, destination byte-count width
STATUS_WIDTH, 2, slot status width
PROFILE_WIDTH, 32, profile counter width

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; starts a pass from slot 0; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the pass completes.
- tbl_rd_index  out  INDEX_WIDTH  read index to table; table returns data combinationally.
- tbl_src_addr  in  SRC_ADDR_WIDTH  table read data.
- tbl_src_size  in  SRC_SIZE_WIDTH  table read data.
- tbl_des_addr  in  DST_ADDR_WIDTH  table read data.
- tbl_des_size  in  DST_SIZE_WIDTH  table read data.
- tbl_status  in  STATUS_WIDTH  table read data.
- tbl_wr_index  out  INDEX_WIDTH  write index.
- tbl_wr_status  out  STATUS_WIDTH  status write data.
- tbl_wr_profile  out  PROFILE_WIDTH  profile write data.
- tbl_set_status  out  1  status write strobe.
- tbl_set_profile  out  1  profile write strobe.
- mm2s_cmd_valid  out  1  MM2S command valid.
- mm2s_cmd_ready  in  1  MM2S command ready.
- mm2s_cmd_addr  out  SRC_ADDR_WIDTH  MM2S command address.
- mm2s_cmd_size  out  SRC_SIZE_WIDTH  MM2S command byte count.
- s2mm_cmd_valid  out  1  S2MM command valid.
- s2mm_cmd_ready  in  1  S2MM command ready.
- s2mm_cmd_addr  out  DST_ADDR_WIDTH  S2MM command address.
- s2mm_cmd_size  out  DST_SIZE_WIDTH  S2MM command byte count.
- mm2s_done  in  1  MM2S completion pulse.
- mm2s_err  in  1  MM2S error pulse.
- s2mm_done  in  1  S2MM completion pulse.
- s2mm_err  in  1  S2MM error pulse.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; index = 0.
  - All outputs 0: busy, done, valids, strobes, write data, command fields, indices.
  - In-flight commands are abandoned; late done/err pulses arriving in IDLE are ignored.
- Status encoding: EMPTY=0, READY=1, DONE=2, ERROR=3.
- FSM:
  - IDLE: start -> FETCH with idx=0.
  - FETCH (1 cycle): tbl_rd_index=idx; register all slot fields.
    - status!=READY -> NEXT.
    - Either size==0 -> WB with ERROR, profile 0.
    - Otherwise -> ISSUE.
  - ISSUE: assert both valids with the registered fields. Each valid drops the cycle after its own valid&ready. When both are accepted -> WAIT.
  - WAIT: collect sticky done/err flags per channel.
    - Pulses arriving during ISSUE, including the same cycle as a handshake, are also captured.
    - Exit when both channels have done or err.
  - WB (1 cycle): tbl_wr_index=idx; tbl_set_status=tbl_set_profile=1.
    - Status: ERROR if any err flag, else DONE.
    - Profile: counter value.
  - NEXT: idx+1. If idx was last slot -> FIN, else FETCH. Index does not wrap into a second pass.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Profile counter:
  - Cleared on FETCH->ISSUE.
  - Increments every cycle in ISSUE/WAIT.
  - Saturates at all-ones.
- Valid/data stability: command fields stay stable while valid is high and not yet accepted.
- Minimum latency per READY slot with ready=1 and done in the first WAIT cycle: FETCH, ISSUE, WAIT, WB, NEXT = 5 cycles; profile = 2.
- Skipped slot costs 2 cycles (FETCH, NEXT).
- start during busy: ignored, no effect.

Decomposition:
- Shared package: status encodings (EMPTY/READY/DONE/ERROR) and FSM state encoding.
- One natural sub-module: dma_cmd_issuer (valid/ready holder plus sticky done/err flag per channel), instantiated twice (MM2S, S2MM).

Test Plan:
- All 4 slots READY, sizes 0x100, ready=1, done 3 cycles after accept -> 4 slot pairs of commands in index order; each slot written DONE (2) with profile 4; single done pulse.
- Slots 1,3 EMPTY -> only slots 0,2 issue commands; slots 1,3 get no writes; done pulse.
- Slot 0 src_size=0 -> no commands; slot 0 written ERROR (3), profile 0.
- mm2s_err pulse on slot 2 while s2mm_done arrives normally -> slot 2 written ERROR; walk continues to slot 3.
- s2mm_cmd_ready held low 10 cycles -> s2mm_cmd_valid and fields held stable; mm2s accepted once only; profile reflects stall.
- reset asserted mid-WAIT -> all outputs 0 immediately; a later done pulse causes no write; next start begins at slot 0.

Source files
------------

// File: rtl/slot_dispatch_seq_pkg.sv
// Shared encodings for the slot dispatch sequencer: slot status values and FSM states.
package slot_dispatch_seq_pkg;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_READY = 2'd1,
      SLOT_DONE  = 2'd2,
      SLOT_ERROR = 2'd3
   } slot_status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_NEXT,
      S_FIN
   } state_e;

endpackage

// File: rtl/slot_dispatch_seq_dma_cmd_issuer.sv
// One DMA channel: holds a command until accepted and collects sticky done/err flags
// for the transfer that command started.
module dma_cmd_issuer #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned SIZE_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  launch_i,
   input  logic                  capture_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [SIZE_WIDTH-1:0] size_i,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [ADDR_WIDTH-1:0] cmd_addr_o,
   output logic [SIZE_WIDTH-1:0] cmd_size_o,
   input  logic                  xfer_done_i,
   input  logic                  xfer_err_i,
   output logic                  accepted_o,
   output logic                  finished_o,
   output logic                  err_o
);

   logic                  valid_q, valid_d;
   logic                  acc_q, acc_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic                  handshake;

   assign handshake = valid_q & cmd_ready_i;

   always_comb begin
      valid_d = valid_q;
      acc_d   = acc_q;
      done_d  = done_q;
      err_d   = err_q;
      addr_d  = addr_q;
      size_d  = size_q;
      if (launch_i) begin
         valid_d = 1'b1;
         acc_d   = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
         addr_d  = addr_i;
         size_d  = size_i;
      end else begin
         if (handshake) begin
            valid_d = 1'b0;
            acc_d   = 1'b1;
         end
         // Completion pulses count even when they race the command handshake.
         if (capture_i && xfer_done_i) done_d = 1'b1;
         if (capture_i && xfer_err_i)  err_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         acc_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         valid_q <= valid_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   assign cmd_valid_o = valid_q;
   assign cmd_addr_o  = addr_q;
   assign cmd_size_o  = size_q;
   assign accepted_o  = acc_q | handshake;
   assign finished_o  = done_q | err_q | (capture_i & (xfer_done_i | xfer_err_i));
   assign err_o       = err_q;

endmodule

// File: rtl/slot_dispatch_seq.sv
// Walks every table slot once per start, runs MM2S+S2MM for READY slots and writes
// back final status plus the ISSUE/WAIT cycle count.
module slot_dispatch_seq
   import slot_dispatch_seq_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH    = 2,
   parameter int unsigned SRC_ADDR_WIDTH = 32,
   parameter int unsigned SRC_SIZE_WIDTH = 26,
   parameter int unsigned DST_ADDR_WIDTH = 32,
   parameter int unsigned DST_SIZE_WIDTH = 26,
   parameter int unsigned STATUS_WIDTH   = 2,
   parameter int unsigned PROFILE_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [INDEX_WIDTH-1:0]    tbl_rd_index,
   input  logic [SRC_ADDR_WIDTH-1:0] tbl_src_addr,
   input  logic [SRC_SIZE_WIDTH-1:0] tbl_src_size,
   input  logic [DST_ADDR_WIDTH-1:0] tbl_des_addr,
   input  logic [DST_SIZE_WIDTH-1:0] tbl_des_size,
   input  logic [STATUS_WIDTH-1:0]   tbl_status,
   output logic [INDEX_WIDTH-1:0]    tbl_wr_index,
   output logic [STATUS_WIDTH-1:0]   tbl_wr_status,
   output logic [PROFILE_WIDTH-1:0]  tbl_wr_profile,
   output logic                      tbl_set_status,
   output logic                      tbl_set_profile,
   output logic                      mm2s_cmd_valid,
   input  logic                      mm2s_cmd_ready,
   output logic [SRC_ADDR_WIDTH-1:0] mm2s_cmd_addr,
   output logic [SRC_SIZE_WIDTH-1:0] mm2s_cmd_size,
   output logic                      s2mm_cmd_valid,
   input  logic                      s2mm_cmd_ready,
   output logic [DST_ADDR_WIDTH-1:0] s2mm_cmd_addr,
   output logic [DST_SIZE_WIDTH-1:0] s2mm_cmd_size,
   input  logic                      mm2s_done,
   input  logic                      mm2s_err,
   input  logic                      s2mm_done,
   input  logic                      s2mm_err
);

   state_e                   state_q, state_d;
   logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
   logic [PROFILE_WIDTH-1:0] prof_q, prof_d;
   logic                     zero_err_q, zero_err_d;

   logic launch, capture;
   logic mm_acc, mm_fin, mm_err_flag;
   logic s2_acc, s2_fin, s2_err_flag;
   logic [PROFILE_WIDTH-1:0] prof_inc;

   assign capture  = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign prof_inc = (prof_q == '1) ? prof_q : prof_q + PROFILE_WIDTH'(1);

   dma_cmd_issuer #(
      .ADDR_WIDTH(SRC_ADDR_WIDTH),
      .SIZE_WIDTH(SRC_SIZE_WIDTH)
   ) u_mm2s (
      .clk         (clk),
      .rst_i       (reset),
      .launch_i    (launch),
      .capture_i   (capture),
      .addr_i      (tbl_src_addr),
      .size_i      (tbl_src_size),
      .cmd_valid_o (mm2s_cmd_valid),
      .cmd_ready_i (mm2s_cmd_ready),
      .cmd_addr_o  (mm2s_cmd_addr),
      .cmd_size_o  (mm2s_cmd_size),
      .xfer_done_i (mm2s_done),
      .xfer_err_i  (mm2s_err),
      .accepted_o  (mm_acc),
      .finished_o  (mm_fin),
      .err_o       (mm_err_flag)
   );

   dma_cmd_issuer #(
      .ADDR_WIDTH(DST_ADDR_WIDTH),
      .SIZE_WIDTH(DST_SIZE_WIDTH)
   ) u_s2mm (
      .clk         (clk),
      .rst_i       (reset),
      .launch_i    (launch),
      .capture_i   (capture),
      .addr_i      (tbl_des_addr),
      .size_i      (tbl_des_size),
      .cmd_valid_o (s2mm_cmd_valid),
      .cmd_ready_i (s2mm_cmd_ready),
      .cmd_addr_o  (s2mm_cmd_addr),
      .cmd_size_o  (s2mm_cmd_size),
      .xfer_done_i (s2mm_done),
      .xfer_err_i  (s2mm_err),
      .accepted_o  (s2_acc),
      .finished_o  (s2_fin),
      .err_o       (s2_err_flag)
   );

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      prof_d          = prof_q;
      zero_err_d      = zero_err_q;
      launch          = 1'b0;
      done            = 1'b0;
      tbl_wr_index    = '0;
      tbl_wr_status   = '0;
      tbl_wr_profile  = '0;
      tbl_set_status  = 1'b0;
      tbl_set_profile = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            prof_d     = '0;
            zero_err_d = 1'b0;
            if (tbl_status != STATUS_WIDTH'(SLOT_READY)) begin
               state_d = S_NEXT;
            end else if ((tbl_src_size == '0) || (tbl_des_size == '0)) begin
               zero_err_d = 1'b1;
               state_d    = S_WB;
            end else begin
               launch  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            prof_d = prof_inc;
            if (mm_acc && s2_acc) state_d = S_WAIT;
         end
         S_WAIT: begin
            prof_d = prof_inc;
            if (mm_fin && s2_fin) state_d = S_WB;
         end
         S_WB: begin
            tbl_wr_index    = idx_q;
            tbl_set_status  = 1'b1;
            tbl_set_profile = 1'b1;
            tbl_wr_profile  = prof_q;
            // Issuer flags are stale on the zero-size path, but that path is ERROR anyway.
            tbl_wr_status   = (zero_err_q || mm_err_flag || s2_err_flag) ?
                              STATUS_WIDTH'(SLOT_ERROR) : STATUS_WIDTH'(SLOT_DONE);
            state_d         = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q == '1) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_q + INDEX_WIDTH'(1);
               state_d = S_FETCH;
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         prof_q     <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         prof_q     <= prof_d;
         zero_err_q <= zero_err_d;
      end
   end

   assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
   assign tbl_rd_index = idx_q;

endmodule
